// File: rtl/roll_pkg.sv
// Shared types, default constants and helpers for the random-roll sequencer.
// Imported by roll_sequencer and roll_tick_gen.
package roll_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_SHOW
  } state_t;

  localparam int DEF_W               = 4;
  localparam int DEF_N_PHASES        = 3;
  localparam int DEF_BASE_INTERVAL   = 1;
  localparam int DEF_SHIFT           = 3;
  localparam int DEF_STEPS_PER_PHASE = 16;
  localparam int DEF_SHOW_CYCLES     = 16;

  // Step interval in cycles for a given phase.
  function automatic int interval(
    input int base,
    input int shift,
    input int phase
  );
    return base << (shift * phase);
  endfunction

  // Counter width able to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/roll_tick_gen.sv
// Interval counter: raises tick on the last cycle of each step interval.
// The interval length is selected by the current speed phase.
module roll_tick_gen
  import roll_pkg::*;
#(
  parameter int N_PHASES      = DEF_N_PHASES,
  parameter int BASE_INTERVAL = DEF_BASE_INTERVAL,
  parameter int SHIFT         = DEF_SHIFT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] phase,
  output logic       tick
);

  localparam int MAX_IV =
    interval(BASE_INTERVAL, SHIFT, N_PHASES - 1);
  localparam int IW = cnt_width(MAX_IV);

  logic [IW-1:0] icnt;
  logic [IW-1:0] lim;

  // Terminal count for the active phase.
  always_comb begin
    lim = IW'(interval(BASE_INTERVAL, SHIFT, int'(phase)) - 1);
  end

  assign tick = enable && (icnt == lim);

  // Count cycles while running; restart on tick or on a new roll.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      icnt <= '0;
    end else if (enable) begin
      icnt <= tick ? '0 : icnt + IW'(1);
    end
  end

endmodule

// File: rtl/roll_sequencer.sv
// Control FSM for the LFSR roll datapath: seeds, steps at a decelerating
// rate, freezes the result and can briefly show the previous roll.
module roll_sequencer
  import roll_pkg::*;
#(
  parameter int W               = DEF_W,
  parameter int N_PHASES        = DEF_N_PHASES,
  parameter int BASE_INTERVAL   = DEF_BASE_INTERVAL,
  parameter int SHIFT           = DEF_SHIFT,
  parameter int STEPS_PER_PHASE = DEF_STEPS_PER_PHASE,
  parameter int SHOW_CYCLES     = DEF_SHOW_CYCLES
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic         i_show,
  input  logic [W-1:0] i_rand,
  output logic         o_seed_load,
  output logic         o_step,
  output logic [W-1:0] o_value,
  output logic [1:0]   o_phase,
  output logic         o_busy,
  output logic         o_done
);

  if (N_PHASES < 1 || N_PHASES > 4 ||
      BASE_INTERVAL < 1 || STEPS_PER_PHASE < 1 ||
      SHOW_CYCLES < 1) begin : g_bad_params
    $error("roll_sequencer: illegal parameter set");
  end

  localparam int SMAX =
    (STEPS_PER_PHASE > SHOW_CYCLES) ? STEPS_PER_PHASE : SHOW_CYCLES;
  localparam int SW = cnt_width(SMAX);

  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_PER_PHASE - 1);
  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYCLES - 1);
  localparam logic [1:0]    PH_LAST   = 2'(N_PHASES - 1);

  state_t        state;
  logic [1:0]    phase;
  logic [SW-1:0] scnt;
  logic [W-1:0]  last;
  logic          tick;
  logic          start_go;
  logic          run;

  assign run      = (state == S_RUN);
  assign start_go = i_start &&
                    (state == S_IDLE || state == S_DONE);

  roll_tick_gen #(
    .N_PHASES      (N_PHASES),
    .BASE_INTERVAL (BASE_INTERVAL),
    .SHIFT         (SHIFT)
  ) u_tick (
    .clk    (i_clk),
    .rst    (i_rst),
    .enable (run),
    .clear  (start_go),
    .phase  (phase),
    .tick   (tick)
  );

  // Status flags come straight from the state register.
  assign o_busy  = run;
  assign o_done  = (state == S_DONE);
  assign o_phase = run ? phase : 2'd0;

  // Main sequencer: roll, stop, and previous-result display.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      phase       <= 2'd0;
      scnt        <= '0;
      o_value     <= '0;
      last        <= '0;
      o_seed_load <= 1'b0;
      o_step      <= 1'b0;
    end else begin
      o_seed_load <= 1'b0;
      o_step      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            state       <= S_RUN;
            phase       <= 2'd0;
            scnt        <= '0;
            o_seed_load <= 1'b1;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            o_value <= i_rand;
            state   <= S_DONE;
          end else if (tick) begin
            o_value <= i_rand;
            if (scnt == STEP_LAST) begin
              if (phase == PH_LAST) begin
                state <= S_DONE;
              end else begin
                phase  <= phase + 2'd1;
                scnt   <= '0;
                o_step <= 1'b1;
              end
            end else begin
              scnt   <= scnt + SW'(1);
              o_step <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (i_start) begin
            last        <= o_value;
            state       <= S_RUN;
            phase       <= 2'd0;
            scnt        <= '0;
            o_seed_load <= 1'b1;
          end else if (i_show) begin
            o_value <= last;
            last    <= o_value;
            scnt    <= '0;
            state   <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (scnt == SHOW_LAST) begin
            o_value <= last;
            last    <= o_value;
            state   <= S_DONE;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_roll_sequencer.sv
// Randomized self-checking bench for roll_sequencer against a
// schedule-based behavioural model of the roll/show rules.
module tb_roll_sequencer;
  import roll_pkg::*;

  localparam int W   = 4;
  localparam int NP  = 3;
  localparam int BI  = 1;
  localparam int SH  = 3;
  localparam int SPP = 16;
  localparam int SC  = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic         show;
  logic [W-1:0] rnd;
  logic         seed_load;
  logic         step;
  logic [W-1:0] value;
  logic [1:0]   phase;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  // model: mode 0 idle, 1 run, 2 done, 3 show
  int           m_mode;
  int           m_age;
  int           m_left;
  int           run_len;
  logic [W-1:0] m_val;
  logic [W-1:0] m_last;
  bit           m_step;
  bit           m_seed;
  bit           tick_at [2048];
  int           ph_at [2048];

  logic [W-1:0] lfsr;
  bit           frc;
  int           n_step;
  int           n_busy;
  int           n3;
  bit           hit;

  always #5 clk = ~clk;

  roll_sequencer #(
    .W               (W),
    .N_PHASES        (NP),
    .BASE_INTERVAL   (BI),
    .SHIFT           (SH),
    .STEPS_PER_PHASE (SPP),
    .SHOW_CYCLES     (SC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_stop      (stop),
    .i_show      (show),
    .i_rand      (rnd),
    .o_seed_load (seed_load),
    .o_step      (step),
    .o_value     (value),
    .o_phase     (phase),
    .o_busy      (busy),
    .o_done      (done)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lfsr_next(
    input logic [W-1:0] l
  );
    return {l[2:0], l[3] ^ l[2]};
  endfunction

  task automatic model(
    input bit           r,
    input bit           st,
    input bit           sp,
    input bit           sh,
    input logic [W-1:0] rv
  );
    logic [W-1:0] t;
    m_step = 1'b0;
    m_seed = 1'b0;
    if (r) begin
      m_mode = 0;
      m_age  = 0;
      m_val  = '0;
      m_last = '0;
      return;
    end
    case (m_mode)
      0: if (st) begin
        m_mode = 1;
        m_age  = 0;
        m_seed = 1'b1;
      end
      1: begin
        if (sp) begin
          m_val  = rv;
          m_mode = 2;
        end else begin
          if (tick_at[m_age]) begin
            m_val = rv;
            if (m_age == run_len - 1) m_mode = 2;
            else m_step = 1'b1;
          end
          m_age++;
        end
      end
      2: begin
        if (st) begin
          m_last = m_val;
          m_mode = 1;
          m_age  = 0;
          m_seed = 1'b1;
        end else if (sh) begin
          t      = m_val;
          m_val  = m_last;
          m_last = t;
          m_mode = 3;
          m_left = SC;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          t      = m_val;
          m_val  = m_last;
          m_last = t;
          m_mode = 2;
        end
      end
    endcase
  endtask

  task automatic cycle();
    bit           s_rst   = rst;
    bit           s_start = start;
    bit           s_stop  = stop;
    bit           s_show  = show;
    logic [W-1:0] s_rnd   = rnd;
    logic         ps      = seed_load;
    logic         pt      = step;
    @(posedge clk);
    model(s_rst, s_start, s_stop, s_show, s_rnd);
    if (ps === 1'b1) lfsr = 4'h1;
    else if (pt === 1'b1) lfsr = lfsr_next(lfsr);
    #1;
    chk("value", value, m_val);
    chk("step", step, m_step);
    chk("seed", seed_load, m_seed);
    chk("busy", busy, m_mode == 1);
    chk("done", done, m_mode == 2);
    chk("phase", phase,
        (m_mode == 1) ? ph_at[m_age] : 0);
    n_step += (step === 1'b1) ? 1 : 0;
    n_busy += (busy === 1'b1) ? 1 : 0;
    if (!frc) rnd = lfsr;
  endtask

  task automatic stop_with(input logic [W-1:0] v);
    frc  = 1'b1;
    rnd  = v;
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    frc  = 1'b0;
    rnd  = lfsr;
  endtask

  task automatic run_to_age(input int a);
    for (int i = 0; i < 3000 && m_mode == 1 && m_age < a; i++)
      cycle();
    chk("reach_age", m_age, a);
  endtask

  initial begin
    int pos;
    int iv;
    pos = 0;
    for (int p = 0; p < NP; p++) begin
      iv = BI << (SH * p);
      for (int s = 0; s < SPP; s++)
        for (int k = 0; k < iv; k++) begin
          ph_at[pos]   = p;
          tick_at[pos] = (k == iv - 1);
          pos++;
        end
    end
    run_len = pos;

    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    show  = 1'b0;
    frc   = 1'b0;
    rnd   = '0;
    lfsr  = 4'h1;
    m_mode = 0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // ignored keys in IDLE
    show = 1'b1;
    stop = 1'b1;
    cycle();
    show = 1'b0;
    stop = 1'b0;
    chk("idle_ign_busy", busy, 0);
    chk("idle_ign_val", value, 0);

    // full roll with ignored noise
    n_step = 0;
    n_busy = 0;
    start  = 1'b1;
    cycle();
    start  = 1'b0;
    chk("seed_first", seed_load, 1);
    chk("busy_first", busy, 1);
    for (int i = 0; i < 1500 && done !== 1'b1; i++) begin
      start = ($urandom_range(0, 15) == 0);
      show  = ($urandom_range(0, 15) == 0);
      cycle();
    end
    start = 1'b0;
    show  = 1'b0;
    chk("roll_done", done, 1);
    chk("step_cnt", n_step, 47);
    chk("run_cycles", n_busy, 1168);

    // early stop at RUN cycle 5, plus ignored start in RUN
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_to_age(2);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("run_start_ign", busy, 1);
    run_to_age(5);
    stop_with(4'hA);
    chk("estop_val", value, 4'hA);
    chk("estop_done", done, 1);
    n_step = 0;
    repeat (10) cycle();
    chk("estop_nostep", n_step, 0);

    // stop coincident with first phase-1 tick
    start = 1'b1;
    cycle();
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (m_mode == 1 && ph_at[m_age] == 1 && tick_at[m_age])
        hit = 1'b1;
      else
        cycle();
    end
    chk("coinc_reach", hit, 1);
    stop_with(4'h6);
    chk("coinc_val", value, 4'h6);
    chk("coinc_done", done, 1);
    n_step = 0;
    repeat (20) cycle();
    chk("coinc_nostep", n_step, 0);

    // two rolls then show previous
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    stop_with(4'h3);
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    stop_with(4'h9);
    show = 1'b1;
    cycle();
    show = 1'b0;
    n3 = (value == 4'h3) ? 1 : 0;
    for (int i = 0; i < 19; i++) begin
      if (m_mode == 3) begin
        start = $urandom_range(0, 1);
        stop  = $urandom_range(0, 1);
        show  = $urandom_range(0, 1);
      end
      cycle();
      start = 1'b0;
      stop  = 1'b0;
      show  = 1'b0;
      n3 += (value == 4'h3) ? 1 : 0;
    end
    chk("show_len", n3, 16);
    chk("show_restore", value, 4'h9);
    chk("show_done", done, 1);
    show = 1'b1;
    cycle();
    show = 1'b0;
    chk("show2_val", value, 4'h3);
    repeat (18) cycle();
    chk("show2_restore", value, 4'h9);

    // reset in phase 1
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_to_age(50);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_val", value, 0);
    chk("rst_step", step, 0);
    chk("rst_busy", busy, 0);
    cycle();
    chk("rst_step2", step, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("rst_seed", seed_load, 1);
    stop_with(4'h7);
    show = 1'b1;
    cycle();
    show = 1'b0;
    chk("rst_last", value, 0);
    repeat (18) cycle();
    chk("rst_restore", value, 4'h7);

    // random soak
    frc = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      rst   = ($urandom_range(0, 799) == 0);
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      show  = ($urandom_range(0, 29) == 0);
      rnd   = W'($urandom);
      cycle();
    end
    rst   = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    show  = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
